// File: rtl/rpsc_pkg.sv
// Shared constants for the RPSC interlock input stage: channel bit positions and
// the first-fault capture state type.
package rpsc_pkg;
  localparam int CH_CARD_POS    = 0;
  localparam int CH_AIR_GRID    = 1;
  localparam int CH_WATER_ANODE = 2;
  localparam int CH_WATER_GRID  = 3;
  localparam int CH_DC_PS       = 4;
  localparam int CH_U_CA_LOW    = 5;
  localparam int CH_I_CA_HIGH   = 6;
  localparam int N_CH_RPSC      = 7;

  typedef enum logic {
    FF_IDLE     = 1'b0,
    FF_CAPTURED = 1'b1
  } ff_state_e;
endpackage

// File: rtl/rpsc_interlock_filter_if.sv
// Contact inputs, operator acknowledge and conditioned status outputs of the
// interlock filter; slave is the filter side, master is the driving side.
interface rpsc_interlock_filter_if #(
  parameter int N_CH = 7
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]  raw_in;
  logic             ack;
  logic [N_CH-1:0]  filt_out;
  logic [N_CH-1:0]  edge_rise;
  logic             trip_any;
  logic [N_CH-1:0]  fault_latched;
  logic             first_valid;
  logic [IDX_W-1:0] first_idx;

  modport master (
    output raw_in, ack,
    input  filt_out, edge_rise, trip_any, fault_latched, first_valid, first_idx
  );

  modport slave (
    input  raw_in, ack,
    output filt_out, edge_rise, trip_any, fault_latched, first_valid, first_idx
  );
endinterface

// File: rtl/rpsc_debounce_ch.sv
// One interlock channel: two-flop synchroniser, stable-count debouncer and a
// registered pulse on the first cycle the filtered level reads 1.
module rpsc_debounce_ch #(
  parameter int                   DB_WIDTH  = 16,
  parameter logic [DB_WIDTH-1:0]  DB_CYCLES = 16'd39062
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic filt,
  output logic edge_rise
);
  localparam logic [DB_WIDTH-1:0] DB_LAST = DB_CYCLES - 1'b1;

  logic                sync_p0;
  logic                sync_p1;
  logic [DB_WIDTH-1:0] cnt;
  logic                accept;

  assign accept = (sync_p1 != filt) && (cnt == DB_LAST);

  // Synchroniser stage boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage boundary: any return to the filtered level restarts the count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      filt      <= 1'b0;
      edge_rise <= 1'b0;
    end else begin
      edge_rise <= accept & sync_p1;
      if (sync_p1 == filt) begin
        cnt <= '0;
      end else if (accept) begin
        cnt  <= '0;
        filt <= sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/rpsc_interlock_filter.sv
// Interlock input conditioning ahead of RPSC card 1: per-channel debounce,
// sticky fault flags and an acknowledge-released first-fault latch.
module rpsc_interlock_filter
  import rpsc_pkg::*;
#(
  parameter int                   N_CH      = 7,
  parameter int                   DB_WIDTH  = 16,
  parameter logic [DB_WIDTH-1:0]  DB_CYCLES = 16'd39062
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rpsc_interlock_filter_if.slave bus
);
  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0]  filt;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fault_q;
  logic [IDX_W-1:0] idx_q;
  ff_state_e        state;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_CH-1:0] v);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    rpsc_debounce_ch #(
      .DB_WIDTH  (DB_WIDTH),
      .DB_CYCLES (DB_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .raw       (bus.raw_in[g]),
      .filt      (filt[g]),
      .edge_rise (rise[g])
    );
  end

  // Sticky flag stage boundary: a new rise outranks a clearing acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= '0;
    end else begin
      fault_q <= (fault_q & ~({N_CH{bus.ack}} & ~filt)) | rise;
    end
  end

  // First-fault stage boundary: idx_q is only meaningful while CAPTURED
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FF_IDLE;
      idx_q <= '0;
    end else begin
      case (state)
        FF_IDLE: begin
          if (|rise) begin
            state <= FF_CAPTURED;
            idx_q <= lowest_set(rise);
          end
        end
        FF_CAPTURED: begin
          if (bus.ack && !(|filt) && !(|rise)) state <= FF_IDLE;
        end
        default: state <= FF_IDLE;
      endcase
    end
  end

  assign bus.filt_out      = filt;
  assign bus.edge_rise     = rise;
  assign bus.trip_any      = |filt;
  assign bus.fault_latched = fault_q;
  assign bus.first_valid   = (state == FF_CAPTURED);
  assign bus.first_idx     = idx_q;
endmodule
